// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous single-port instruction/data RAM
// among NCORES cores. Round-robin arbitration with bounded bursts; every
// access takes two clocks (ADDR, then DATA where acq pulses).
// Optional feature: define IMEM_BCAST_EN to serve an identical read from
// all cores as a single broadcast access.
module imem_arbiter #(
    parameter int NCORES    = 4,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCORES-1:0]           rden,
    input  logic [NCORES-1:0]           wren,
    input  logic [NCORES*AW-1:0]        addr,
    input  logic [NCORES*DW-1:0]        din,
    input  logic [DW-1:0]               ram_q,
    output logic [NCORES-1:0]           acq,
    output logic [NCORES*DW-1:0]        dq,
    output logic [AW-1:0]               ram_addr,
    output logic [DW-1:0]               ram_din,
    output logic                        ram_wren,
    output logic [$clog2(NCORES)-1:0]   grant_id
);

    localparam int IW = $clog2(NCORES);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state, state_n;
    logic [NCORES-1:0] req;
    logic              grant;
    logic [IW-1:0]     last;
    logic [IW-1:0]     win;
    logic              found;
    logic [CW-1:0]     cnt;
    logic              bcast;
    logic              bc_hit;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_din;
    logic              win_wr;

    assign req = rden | wren;
    assign dq  = {NCORES{ram_q}};

    // Winner selection. A zero burst count means nothing has been granted
    // since reset, so the repeat rule is skipped and core 0 gets first pick.
    always_comb begin
        win   = last;
        found = 1'b0;
        if (cnt != '0 && req[last] && cnt < BMAX) begin
            found = 1'b1;
        end
        for (int unsigned k = 1; k <= NCORES; k++) begin
            int unsigned idx;
            idx = (32'(last) + k) % NCORES;
            if (!found && req[IW'(idx)]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
    end

    // Mux the winning core's address, data and direction.
    always_comb begin
        win_addr = '0;
        win_din  = '0;
        win_wr   = 1'b0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (win == IW'(i)) begin
                win_addr = addr[i*AW +: AW];
                win_din  = din[i*DW +: DW];
                win_wr   = wren[i];
            end
        end
    end

    // Broadcast detection: every core reads the same address, nobody writes.
    always_comb begin
`ifdef IMEM_BCAST_EN
        bc_hit = (&rden) && !(|wren);
        for (int unsigned i = 1; i < NCORES; i++) begin
            if (addr[i*AW +: AW] != addr[AW-1:0]) begin
                bc_hit = 1'b0;
            end
        end
`else
        bc_hit = 1'b0;
`endif
    end

    // Next-state logic: grant from IDLE or DATA, ADDR always moves to DATA.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (|req) begin
                    grant   = 1'b1;
                    state_n = ADDR;
                end else begin
                    state_n = IDLE;
                end
            end
            ADDR:    state_n = DATA;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // RAM port, completion pulse, and round-robin/burst bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acq      <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
            grant_id <= '0;
            last     <= IW'(NCORES - 1);
            cnt      <= '0;
            bcast    <= 1'b0;
        end else begin
            acq      <= '0;
            ram_wren <= 1'b0;
            if (grant) begin
                if (bc_hit) begin
                    bcast    <= 1'b1;
                    ram_addr <= addr[AW-1:0];
                end else begin
                    bcast    <= 1'b0;
                    ram_addr <= win_addr;
                    ram_din  <= win_din;
                    ram_wren <= win_wr;
                    grant_id <= win;
                    last     <= win;
                    if (win == last && cnt != '0) begin
                        if (cnt < BMAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= CW'(1);
                    end
                end
            end else if (state == ADDR) begin
                if (bcast) begin
                    acq <= '1;
                end else begin
                    acq[grant_id] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a transaction-level model predicts each
// grant and its expected completion; a monitor checks every acq pulse.
module tb_imem_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] rden = '0;
    logic [NC-1:0] wren = '0;
    logic [NC*AW-1:0] addr = '0;
    logic [NC*DW-1:0] din = '0;
    logic [DW-1:0] ram_q;
    logic [NC-1:0] acq;
    logic [NC*DW-1:0] dq;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wren;
    logic [1:0]    grant_id;

    always #5 clk = ~clk;

    imem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .BURST_MAX(BM)) u_dut (
        .clk(clk), .rst_n(rst_n), .rden(rden), .wren(wren), .addr(addr),
        .din(din), .ram_q(ram_q), .acq(acq), .dq(dq), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_wren(ram_wren), .grant_id(grant_id)
    );

    // Synchronous single-port RAM, one clock read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic [3:0] mask;
        int         gid;
        logic [7:0] data;
        bit         chk;
        bit         bc;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state.
    bit         m_busy;
    int         m_last;
    int         m_cnt;
    logic [7:0] shadow [256];
    bit         valid [256];
    bit         exp_wren;
    logic [7:0] exp_addr, exp_din;
    bit         pend_wr;
    int         pend_a;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        if (m_busy && pend_wr) valid[pend_a] = 1'b0;
        m_busy = 1'b0;
        m_last = NC - 1;
        m_cnt = 0;
        exp_wren = 1'b0;
        pend_wr = 1'b0;
        q.delete();
    endtask

    // One rising edge of the model: either the second half of an access, or
    // a chance to start a new one from the current requests.
    task automatic model_step();
        exp_t e;
        logic [3:0] rq;
        int w;
        int a;
        exp_wren = 1'b0;
        if (m_busy) begin
            m_busy = 1'b0;
            return;
        end
        rq = rden | wren;
        if (rq == 4'b0) return;
`ifdef IMEM_BCAST_EN
        if (rden == 4'hF && wren == 4'h0 && addr[7:0] == addr[15:8] &&
            addr[7:0] == addr[23:16] && addr[7:0] == addr[31:24]) begin
            a = int'(addr[7:0]);
            e.mask = 4'hF; e.gid = 0; e.data = shadow[a]; e.chk = valid[a];
            e.bc = 1'b1; e.cyc = cyc;
            q.push_back(e);
            pend_wr = 1'b0;
            m_busy = 1'b1;
            return;
        end
`endif
        w = -1;
        if (m_cnt > 0 && rq[m_last] && m_cnt < BM) begin
            w = m_last;
        end else begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (rq[c]) begin
                    w = c;
                    break;
                end
            end
        end
        if (w == m_last && m_cnt > 0) m_cnt = (m_cnt < BM) ? m_cnt + 1 : BM;
        else m_cnt = 1;
        m_last = w;
        a = int'(addr[w*8 +: 8]);
        e.mask = 4'b1 << w; e.gid = w; e.bc = 1'b0; e.cyc = cyc;
        if (wren[w]) begin
            shadow[a] = din[w*8 +: 8];
            valid[a] = 1'b1;
            exp_wren = 1'b1;
            exp_addr = 8'(a);
            exp_din = din[w*8 +: 8];
            pend_wr = 1'b1;
            pend_a = a;
            e.data = 8'h00; e.chk = 1'b0;
        end else begin
            pend_wr = 1'b0;
            e.data = shadow[a]; e.chk = valid[a];
        end
        q.push_back(e);
        m_busy = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rden = '0; wren = '0;
    endtask

    task automatic do_access(input int core, input bit rd, input bit wr,
                             input logic [7:0] a, input logic [7:0] d);
        clear_inputs();
        rden[core] = rd;
        wren[core] = wr;
        addr[core*8 +: 8] = a;
        din[core*8 +: 8] = d;
        tick();
        clear_inputs();
        tick();
    endtask

    // Monitor: compares every completion against the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ram_wren", ram_wren, exp_wren);
            if (exp_wren) begin
                check("ram_addr", ram_addr, exp_addr);
                check("ram_din", ram_din, exp_din);
            end
            if (q.size() > 0 && cyc > q[0].cyc + 1) begin
                check("acq_missing", acq, q[0].mask);
                void'(q.pop_front());
            end else if (acq != 4'b0) begin
                if (q.size() == 0) begin
                    check("acq_unexpected", acq, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("acq", acq, mon_e.mask);
                    check("acq_latency", cyc, mon_e.cyc + 1);
                    if (!mon_e.bc) check("grant_id", grant_id, mon_e.gid);
                    if (mon_e.chk) begin
                        if (mon_e.bc) begin
                            for (int i = 0; i < NC; i++) check("dq_bcast", dq[i*8 +: 8], mon_e.data);
                        end else begin
                            check("dq", dq[mon_e.gid*8 +: 8], mon_e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) valid[i] = 1'b0;
        pend_wr = 1'b0;
        m_busy = 1'b0;
        model_reset();

        // Reset with a request already waiting on core 2.
        rden = 4'b0100;
        addr[23:16] = 8'h10;
        repeat (3) tick();
        check("rst_acq", acq, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_grant_id", grant_id, 0);
        rst_n = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Preload a small address range through the arbiter.
        for (int i = 0; i < 16; i++) do_access(i % NC, 1'b0, 1'b1, 8'(i), 8'($urandom));
        do_access(0, 1'b0, 1'b1, 8'h10, 8'hA5);
        do_access(3, 1'b0, 1'b1, 8'h05, 8'h77);

        // Single read, write-then-read, read+write treated as write.
        do_access(2, 1'b1, 1'b0, 8'h10, 8'h00);
        do_access(1, 1'b0, 1'b1, 8'h20, 8'h3C);
        do_access(1, 1'b1, 1'b0, 8'h20, 8'h00);
        do_access(3, 1'b1, 1'b1, 8'h21, 8'h99);
        do_access(0, 1'b1, 1'b0, 8'h21, 8'h00);

        // Address changed after the grant edge must not affect the access.
        clear_inputs();
        rden[0] = 1'b1; addr[7:0] = 8'h03;
        tick();
        rden[0] = 1'b0; addr[7:0] = 8'h04;
        tick();

        // All cores held: round-robin with bursts.
        for (int i = 0; i < NC; i++) addr[i*8 +: 8] = 8'(i + 8);
        rden = 4'hF;
        repeat (24) tick();

        // Cores 0 and 3 held: bursts of BURST_MAX alternate.
        clear_inputs();
        tick(); tick();
        rden = 4'b1001;
        repeat (34) tick();

        // Identical read from all cores.
        clear_inputs();
        tick(); tick();
        for (int i = 0; i < NC; i++) addr[i*8 +: 8] = 8'h05;
        rden = 4'hF;
        repeat (10) tick();

        // Reset in the ADDR cycle of a core 1 write.
        clear_inputs();
        tick(); tick();
        wren[1] = 1'b1; addr[15:8] = 8'h30; din[15:8] = 8'h5E;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_ram_wren", ram_wren, 0);
        check("abort_acq", acq, 0);
        tick();
        clear_inputs();
        rden = 4'b0011;
        addr[7:0] = 8'h01; addr[15:8] = 8'h02;
        rst_n = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    for (int i = 0; i < NC; i++) addr[i*8 +: 8] = 8'h05;
                    rden = 4'hF; wren = 4'h0;
                end else begin
                    for (int i = 0; i < NC; i++) begin
                        int r;
                        r = int'($urandom_range(0, 4));
                        rden[i] = (r == 1 || r == 3);
                        wren[i] = (r == 2 || r == 3);
                        addr[i*8 +: 8] = 8'($urandom_range(0, 15));
                        din[i*8 +: 8] = 8'($urandom);
                    end
                end
            end
            tick();
        end

        clear_inputs();
        repeat (4) tick();
        check("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
